mem_port_arbiter: RTL and testbench

Shares the single-ported unified RAM of the pipelined MIPS CPU between the instruction-fetch stage and the data-memory stage. It accepts one access at a time, sequences the RAM through a fixed-latency access, returns read data with a one-cycle ready pulse, and drives the pipeline stall lines while a requester waits. It sits between `dataPath` and the RAM and replaces the separate instruction and data memory ports.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter shared by instruction fetch and data memory stages.
// One fixed-latency access at a time, round-robin on ties, one-cycle ready pulses.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ready,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_ready,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_if,
   output logic              stall_mem
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACC_IF = 2'd1,
      ACC_DM = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [3:0] LAT = 4'(MEM_LAT);

   state_t     state;
   logic [3:0] cnt;
   logic       last_dm;
   logic       dm_req;
   logic       grant_dm;
   logic       last_cyc;

   assign dm_req    = dm_read | dm_write;
   // On a tie the port that did not win last time gets the RAM.
   assign grant_dm  = dm_req & (~if_req | ~last_dm);
   assign last_cyc  = (cnt == LAT);

   assign stall_if  = if_req & ~if_ready;
   assign stall_mem = dm_req & ~dm_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         last_dm   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_rdata  <= '0;
         dm_rdata  <= '0;
         if_ready  <= 1'b0;
         dm_ready  <= 1'b0;
      end else begin
         if_ready <= 1'b0;
         dm_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (if_req | dm_req) begin
                  mem_en  <= 1'b1;
                  cnt     <= 4'd1;
                  last_dm <= grant_dm;
                  if (grant_dm) begin
                     mem_addr  <= dm_addr;
                     mem_wdata <= dm_wdata;
                     mem_we    <= dm_write;
                     state     <= ACC_DM;
                  end else begin
                     mem_addr  <= if_addr;
                     mem_wdata <= '0;
                     mem_we    <= 1'b0;
                     state     <= ACC_IF;
                  end
               end
            end
            ACC_IF, ACC_DM: begin
               // RAM-side registers stay frozen until the last access cycle.
               if (last_cyc) begin
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  cnt    <= 4'd0;
                  state  <= DONE;
                  if (state == ACC_IF) begin
                     if_rdata <= mem_rdata;
                     if_ready <= 1'b1;
                  end else begin
                     if (!mem_we) begin
                        dm_rdata <= mem_rdata;
                     end
                     dm_ready <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: RAM model, queued expectations, and a
// negedge monitor; a second instance exercises the single-cycle-latency build.
module tb_mem_port_arbiter;
   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int LAT = 2;

   typedef struct packed {
      logic          wr;
      logic [DW-1:0] data;
   } dm_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic          if_req = 1'b0, dm_read = 1'b0, dm_write = 1'b0;
   logic [AW-1:0] if_addr = '0, dm_addr = '0;
   logic [DW-1:0] dm_wdata = '0;
   logic [DW-1:0] if_rdata, dm_rdata, mem_wdata, mem_rdata;
   logic [AW-1:0] mem_addr;
   logic          if_ready, dm_ready, mem_en, mem_we, stall_if, stall_mem;

   logic          if_req1 = 1'b0, dm_read1 = 1'b0, dm_write1 = 1'b0;
   logic [AW-1:0] if_addr1 = '0, dm_addr1 = '0;
   logic [DW-1:0] dm_wdata1 = '0;
   logic [DW-1:0] if_rdata1, dm_rdata1, mem_wdata1, mem_rdata1;
   logic [AW-1:0] mem_addr1;
   logic          if_ready1, dm_ready1, mem_en1, mem_we1, stall_if1, stall_mem1;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_rdata(dm_rdata), .dm_ready(dm_ready),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
   );

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_ready(if_ready1),
      .dm_read(dm_read1), .dm_write(dm_write1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
      .dm_rdata(dm_rdata1), .dm_ready(dm_ready1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .mem_rdata(mem_rdata1), .stall_if(stall_if1), .stall_mem(stall_mem1)
   );

   // Power-on RAM contents, shared by the RAM models and the reference model.
   function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
      if (a == 8'h10) return 32'h8C02_0004;
      return {8'hA5, a, ~a, a ^ 8'h3C};
   endfunction

   // RAM models: data is only valid in the last cycle of an access.
   logic [DW-1:0] ram0 [256];
   logic [DW-1:0] ram1 [256];
   bit            wr0  [256];
   bit            wr1  [256];
   int            acc0, acc1;

   always @(posedge clk or posedge rst) begin
      if (rst) acc0 <= 0;
      else if (mem_en) acc0 <= acc0 + 1;
      else acc0 <= 0;
   end
   always @(posedge clk or posedge rst) begin
      if (rst) acc1 <= 0;
      else if (mem_en1) acc1 <= acc1 + 1;
      else acc1 <= 0;
   end
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         ram0[mem_addr] <= mem_wdata;
         wr0[mem_addr]  <= 1'b1;
      end
      if (mem_en1 && mem_we1) begin
         ram1[mem_addr1] <= mem_wdata1;
         wr1[mem_addr1]  <= 1'b1;
      end
   end
   assign mem_rdata  = (mem_en && !mem_we && acc0 == LAT - 1) ?
                       (wr0[mem_addr] ? ram0[mem_addr] : init_word(mem_addr)) : 32'hBAD0_BAD0;
   assign mem_rdata1 = (mem_en1 && !mem_we1 && acc1 == 0) ?
                       (wr1[mem_addr1] ? ram1[mem_addr1] : init_word(mem_addr1)) : 32'hBAD1_BAD1;

   // Reference model: architectural memory view plus expected responses.
   logic [DW-1:0] model [256];
   logic [DW-1:0] exp_if [$];
   dm_exp_t       exp_dm [$];

   int vecs = 0;
   int errs = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor
   logic          prev_ifr = 1'b0, prev_dmr = 1'b0;
   logic [DW-1:0] prev_dmrd = '0;
   int            run_en = 0, run_we = 0;

   initial begin
      dm_exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            run_en = 0;
            run_we = 0;
         end else begin
            chk("stall_if", 32'(stall_if), 32'(if_req & ~if_ready));
            chk("stall_mem", 32'(stall_mem), 32'((dm_read | dm_write) & ~dm_ready));
            if (if_ready) begin
               chk("if_ready_width", 32'(prev_ifr), 32'd0);
               if (exp_if.size() == 0) begin
                  vecs++; errs++;
                  $display("FAIL if_ready_unexpected: got pulse, expected none");
               end else begin
                  chk("if_rdata", if_rdata, exp_if.pop_front());
               end
            end
            if (dm_ready) begin
               chk("dm_ready_width", 32'(prev_dmr), 32'd0);
               if (exp_dm.size() == 0) begin
                  vecs++; errs++;
                  $display("FAIL dm_ready_unexpected: got pulse, expected none");
               end else begin
                  e = exp_dm.pop_front();
                  if (e.wr) chk("dm_rdata_hold_on_write", dm_rdata, prev_dmrd);
                  else      chk("dm_rdata", dm_rdata, e.data);
               end
            end
            if (mem_en) run_en++;
            else if (run_en != 0) begin
               chk("mem_en_cycles", 32'(run_en), 32'(LAT));
               run_en = 0;
            end
            if (mem_we) run_we++;
            else if (run_we != 0) begin
               chk("mem_we_cycles", 32'(run_we), 32'(LAT));
               run_we = 0;
            end
         end
         prev_ifr  = if_ready;
         prev_dmr  = dm_ready;
         prev_dmrd = dm_rdata;
      end
   end

   task automatic wait_if(output int lat);
      lat = 0;
      @(negedge clk);
      while (!if_ready && lat < 100) begin
         lat++;
         @(negedge clk);
      end
      if (!if_ready) begin
         vecs++; errs++;
         $display("FAIL if_ready_timeout: got no pulse after %0d cycles, expected one", lat);
      end
   endtask

   task automatic wait_dm(output int lat);
      lat = 0;
      @(negedge clk);
      while (!dm_ready && lat < 100) begin
         lat++;
         @(negedge clk);
      end
      if (!dm_ready) begin
         vecs++; errs++;
         $display("FAIL dm_ready_timeout: got no pulse after %0d cycles, expected one", lat);
      end
   endtask

   // exp_lat == 0 means only the contention bound applies.
   task automatic if_access(input logic [AW-1:0] a, input int exp_lat);
      int lat;
      @(posedge clk); #1;
      if_req  = 1'b1;
      if_addr = a;
      exp_if.push_back(model[a]);
      wait_if(lat);
      if (exp_lat > 0) chk("if_latency", 32'(lat), 32'(exp_lat));
      else             chk("if_latency_bound", 32'(lat <= 2 * LAT + 4), 32'd1);
      @(posedge clk); #1;
      if_req = 1'b0;
   endtask

   task automatic dm_access(input logic rd, input logic wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input int exp_lat);
      int lat;
      @(posedge clk); #1;
      dm_read  = rd;
      dm_write = wr;
      dm_addr  = a;
      dm_wdata = d;
      if (wr) begin
         model[a] = d;
         exp_dm.push_back({1'b1, d});
      end else begin
         exp_dm.push_back({1'b0, model[a]});
      end
      wait_dm(lat);
      if (exp_lat > 0) chk("dm_latency", 32'(lat), 32'(exp_lat));
      else             chk("dm_latency_bound", 32'(lat <= 2 * LAT + 4), 32'd1);
      @(posedge clk); #1;
      dm_read  = 1'b0;
      dm_write = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion by time limit, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, pulses, en_cyc;
      logic [DW-1:0] got;
      for (int a = 0; a < 256; a++) model[a] = init_word(8'(a));

      // Reset state
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_if_rdata", if_rdata, 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_ctrl", 32'({mem_en, mem_we, if_ready, dm_ready, stall_if, stall_mem}), 32'd0);
      chk("rst_ctrl_lat1", 32'({mem_en1, mem_we1, if_ready1, dm_ready1}), 32'd0);
      rst = 1'b0;

      // Ties from reset: DM first, then IF after the next IDLE
      fork
         dm_access(1'b1, 1'b0, 8'h90, '0, LAT + 1);
         if_access(8'h20, 2 * LAT + 3);
      join
      // Single fetch
      if_access(8'h10, LAT + 1);
      // IF was granted last, so DM wins this tie too
      fork
         dm_access(1'b1, 1'b0, 8'h94, '0, LAT + 1);
         if_access(8'h24, 2 * LAT + 3);
      join
      dm_access(1'b1, 1'b0, 8'h98, '0, LAT + 1);
      // DM was granted last, so IF wins now
      fork
         dm_access(1'b1, 1'b0, 8'h9C, '0, 2 * LAT + 3);
         if_access(8'h28, LAT + 1);
      join

      // Write then read
      dm_access(1'b0, 1'b1, 8'hFA, 32'h0000_0005, LAT + 1);
      dm_access(1'b1, 1'b0, 8'hFA, '0, LAT + 1);

      // Reset in the middle of a write
      @(posedge clk); #1;
      dm_write = 1'b1;
      dm_addr  = 8'hC0;
      dm_wdata = 32'h1234_5678;
      model[8'hC0] = 32'h1234_5678;
      exp_dm.push_back({1'b1, 32'h1234_5678});
      @(posedge clk); #2;
      chk("pre_rst_mem_we", 32'(mem_we), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_mem_en", 32'(mem_en), 32'd0);
      chk("rst_async_mem_we", 32'(mem_we), 32'd0);
      chk("rst_async_dm_ready", 32'(dm_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      wait_dm(lat);
      chk("rst_retry_latency", 32'(lat), 32'(LAT + 1));
      @(posedge clk); #1;
      dm_write = 1'b0;
      dm_access(1'b1, 1'b0, 8'hC0, '0, LAT + 1);

      // Randomised traffic on both ports
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               if_access(8'($urandom_range(0, 127)), 0);
            end
         end
         begin
            int unsigned r;
            for (int j = 0; j < 40; j++) begin
               repeat ($urandom_range(0, 3)) @(posedge clk);
               r = $urandom_range(0, 3);
               dm_access(r != 2, r >= 2, 8'(8'h80 | $urandom_range(0, 127)), $urandom, 0);
            end
         end
      join

      // Single-cycle RAM build
      @(posedge clk); #1;
      if_req1 = 1'b1; if_addr1 = 8'h33;
      lat = 0;
      @(negedge clk);
      while (!if_ready1 && lat < 100) begin lat++; @(negedge clk); end
      chk("lat1_if_latency", 32'(lat), 32'd2);
      chk("lat1_if_rdata", if_rdata1, init_word(8'h33));
      @(posedge clk); #1;
      if_req1 = 1'b0;
      @(posedge clk); #1;
      dm_read1 = 1'b1; dm_addr1 = 8'h91;
      lat = 0;
      @(negedge clk);
      while (!dm_ready1 && lat < 100) begin lat++; @(negedge clk); end
      chk("lat1_dm_latency", 32'(lat), 32'd2);
      chk("lat1_dm_rdata", dm_rdata1, init_word(8'h91));
      @(posedge clk); #1;
      dm_read1 = 1'b0;

      // Fetch dropped right after its issue edge
      @(posedge clk); #1;
      if_req1 = 1'b1; if_addr1 = 8'h44;
      @(posedge clk); #1;
      if_req1 = 1'b0;
      pulses = 0; en_cyc = 0; got = '0;
      repeat (8) begin
         @(negedge clk);
         if (mem_en1) en_cyc++;
         if (if_ready1) begin
            pulses++;
            got = if_rdata1;
         end
      end
      chk("drop_ready_pulses", 32'(pulses), 32'd1);
      chk("drop_mem_en_cycles", 32'(en_cyc), 32'd1);
      chk("drop_if_rdata", got, init_word(8'h44));

      repeat (5) @(posedge clk);
      chk("if_queue_drained", 32'(exp_if.size()), 32'd0);
      chk("dm_queue_drained", 32'(exp_dm.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
